// File: rtl/agu_mem_port_if.sv
// ---------------------------------------------------------------------------
// agu_mem_port_if
// Bundles the request/response signals between the address-generation unit
// (master) and the data-memory port (slave).
//   ld_addr / enable_ld_write        : load request, word address
//   st_addr / st_data / enable_st_write : store request
//   ld_data / ld_valid               : registered load result and its pulse
//   st_stall                         : store buffer full, hold off stores
//   st_overflow                      : sticky, a store was dropped
//   sb_empty                         : store buffer holds no entries
// ---------------------------------------------------------------------------
interface agu_mem_port_if;
  logic [31:0] ld_addr;
  logic        enable_ld_write;
  logic [31:0] st_addr;
  logic        enable_st_write;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        st_stall;
  logic        st_overflow;
  logic        sb_empty;

  modport master (
    output ld_addr, enable_ld_write, st_addr, enable_st_write, st_data,
    input  ld_data, ld_valid, st_stall, st_overflow, sb_empty
  );

  modport slave (
    input  ld_addr, enable_ld_write, st_addr, enable_st_write, st_data,
    output ld_data, ld_valid, st_stall, st_overflow, sb_empty
  );
endinterface

// File: rtl/agu_mem_port.sv
// ---------------------------------------------------------------------------
// agu_mem_port
// Data-memory port downstream of the address-generation unit. Holds a
// single-port data memory (2^ADDR_W x 32) and a SB_DEPTH-entry store buffer.
// Loads own the memory port; buffered stores drain on cycles without a load.
// Loads see buffered stores through forwarding (youngest match wins); a store
// issued in the same cycle as a load is ordered after that load.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous, active-high reset
//   bus  : agu_mem_port_if.slave (requests in, load result and status out)
// Parameters:
//   ADDR_W   : memory index width (upper address bits ignored)
//   SB_DEPTH : store-buffer entries, power of 2 and at least 2
// ---------------------------------------------------------------------------
module agu_mem_port #(
  parameter int ADDR_W   = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  agu_mem_port_if.slave  bus
);

  localparam int PTR_W     = $clog2(SB_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } sb_entry_t;

  // Storage
  logic [31:0] mem_q [MEM_DEPTH];
  sb_entry_t   sb_q  [SB_DEPTH];

  // Control state
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             ld_valid_q, ld_valid_d;
  logic             st_overflow_q, st_overflow_d;

  // Per-cycle decode
  logic [ADDR_W-1:0] ld_idx, st_idx;
  logic              sb_full;
  logic              drain;
  logic              push;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PTR_W-1:0]  slot;
  sb_entry_t         head;

  // Upper address bits carry no meaning here; collected so they read as used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ld_addr[31:ADDR_W], bus.st_addr[31:ADDR_W]};

  assign ld_idx = bus.ld_addr[ADDR_W-1:0];
  assign st_idx = bus.st_addr[ADDR_W-1:0];
  assign head   = sb_q[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    sb_full  = (count_q == CNT_W'(SB_DEPTH));
    drain    = 1'b0;
    push     = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;

    // The load owns the port; otherwise the head entry drains.
    drain = !bus.enable_ld_write && (count_q != '0);
    // A full buffer still takes a store when the head leaves this cycle.
    push  = bus.enable_st_write && (!sb_full || drain);

    // Forwarding scans oldest to youngest over entries present before this
    // cycle's push, so the last match (youngest) wins and the same-cycle
    // store is never seen by the load.
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sb_q[slot].idx == ld_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_q[slot].data;
      end
    end
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PTR_W'(drain);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    count_d       = count_q + CNT_W'(push) - CNT_W'(drain);
    st_overflow_d = st_overflow_q | (bus.enable_st_write && !push);
    ld_valid_d    = bus.enable_ld_write;
    ld_data_d     = ld_data_q;
    if (bus.enable_ld_write) begin
      ld_data_d = fwd_hit ? fwd_data : mem_q[ld_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ld_data_q     <= '0;
      ld_valid_q    <= 1'b0;
      st_overflow_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ld_data_q     <= ld_data_d;
      ld_valid_q    <= ld_valid_d;
      st_overflow_q <= st_overflow_d;
    end
  end

  // NOTE: memory and buffer payload carry no reset; validity lives in the
  // pointers and count. Writes are suppressed during RST so pending stores
  // are discarded rather than drained.
  always_ff @(posedge CLK) begin
    if (!RST && drain) begin
      mem_q[head.idx] <= head.data;
    end
    if (!RST && push) begin
      sb_q[wr_ptr_q] <= '{idx: st_idx, data: bus.st_data};
    end
  end

  assign bus.ld_data     = ld_data_q;
  assign bus.ld_valid    = ld_valid_q;
  assign bus.st_stall    = sb_full;
  assign bus.st_overflow = st_overflow_q;
  assign bus.sb_empty    = (count_q == '0);

endmodule

// File: tb/tb_agu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_agu_mem_port
// Drives agu_mem_port one cycle at a time. A reference model (memory array
// plus a FIFO queue of pending stores) predicts each load result, which is
// pushed to a scoreboard queue when the load is driven and popped when the
// DUT raises ld_valid. Status outputs are compared against the model after
// every edge.
// ---------------------------------------------------------------------------
module tb_agu_mem_port;

  localparam int ADDR_W   = 8;
  localparam int SB_DEPTH = 4;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } ent_t;

  logic CLK;
  logic RST;
  agu_mem_port_if bus ();

  agu_mem_port #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model
  logic [31:0] mem_m [1 << ADDR_W];
  ent_t        sbq [$];
  logic [31:0] exp_q [$];
  logic        m_ovf;
  logic [31:0] m_ld_data;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: predict, drive, clock, compare.
  task automatic step(input logic rst, input logic ld, input logic [31:0] la,
                      input logic st, input logic [31:0] sa, input logic [31:0] sd);
    logic        exp_valid;
    logic [31:0] val;
    ent_t        e;
    exp_valid = 1'b0;
    if (rst) begin
      sbq.delete();
      m_ovf     = 1'b0;
      m_ld_data = '0;
    end else begin
      exp_valid = ld;
      if (ld) begin
        val = mem_m[la[ADDR_W-1:0]];
        foreach (sbq[k]) if (sbq[k].idx == la[ADDR_W-1:0]) val = sbq[k].data;
        exp_q.push_back(val);
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        mem_m[e.idx] = e.data;
      end
      if (st) begin
        if (sbq.size() < SB_DEPTH) begin
          e.idx  = sa[ADDR_W-1:0];
          e.data = sd;
          sbq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end

    RST                 = rst;
    bus.enable_ld_write = ld;
    bus.ld_addr         = la;
    bus.enable_st_write = st;
    bus.st_addr         = sa;
    bus.st_data         = sd;
    @(posedge CLK);
    #1;

    check("ld_valid", 32'(bus.ld_valid), 32'(exp_valid));
    if (bus.ld_valid === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        m_ld_data = exp_q.pop_front();
        check("ld_data", bus.ld_data, m_ld_data);
      end
    end else begin
      check("ld_hold", bus.ld_data, m_ld_data);
    end
    check("st_stall", 32'(bus.st_stall), 32'(sbq.size() == SB_DEPTH));
    check("sb_empty", 32'(bus.sb_empty), 32'(sbq.size() == 0));
    check("st_overflow", 32'(bus.st_overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic st_only(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, '0, 1'b1, a, d);
  endtask

  task automatic ld_only(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, '0, '0);
  endtask

  // Addresses that hold known data once the directed phase is done.
  logic [7:0] known [11];

  initial begin
    checks    = 0;
    errors    = 0;
    m_ovf     = 1'b0;
    m_ld_data = '0;
    foreach (mem_m[k]) mem_m[k] = '0;
    known = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h60, 8'h61, 8'h62};

    // Reset then idle
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("rst_ld_data", bus.ld_data, 32'h0);
    idle(1);

    // Forwarding from the buffer, then drain
    st_only(32'h10, 32'hDEADBEEF);
    ld_only(32'h10);
    idle(2);
    check("fwd_drained", 32'(bus.sb_empty), 32'd1);

    // Youngest match wins while loads block draining
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 32'h11111111);
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 32'h22222222);
    ld_only(32'h20);
    check("youngest", bus.ld_data, 32'h22222222);
    idle(3);

    // Same-cycle load and store: load returns prior value
    st_only(32'h30, 32'h5);
    idle(2);
    step(1'b0, 1'b1, 32'h30, 1'b1, 32'h30, 32'h9);
    check("same_cycle_old", bus.ld_data, 32'h5);
    idle(2);
    ld_only(32'h30);
    check("same_cycle_new", bus.ld_data, 32'h9);

    // Fill, overflow under load, accept-on-drain when full
    for (int i = 0; i < SB_DEPTH; i++)
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h40 + i, 32'hA000_0000 + i);
    check("full_stall", 32'(bus.st_stall), 32'd1);
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h48, 32'hBAD0BAD0);
    check("overflow_set", 32'(bus.st_overflow), 32'd1);
    st_only(32'h50, 32'h5050_5050);
    check("full_accept", 32'(bus.st_stall), 32'd1);
    idle(SB_DEPTH + 1);
    check("overflow_sticky", 32'(bus.st_overflow), 32'd1);
    ld_only(32'h50);
    ld_only(32'h43);

    // Reset with stores pending: memory keeps pre-store values
    for (int i = 0; i < 3; i++) st_only(32'h60 + i, 32'hC000_0000 + i);
    idle(4);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h60 + i, 32'hE000_0000 + i);
    step(1'b1, 1'b1, 32'h60, 1'b0, '0, '0);
    check("rst_mid_empty", 32'(bus.sb_empty), 32'd1);
    for (int i = 0; i < 3; i++) ld_only(32'h60 + i);
    check("rst_mid_old", bus.ld_data, 32'hC000_0002);

    // Random mix over known addresses, upper bits scrambled
    for (int i = 0; i < 60; i++) begin
      logic        ld;
      logic        st;
      logic [31:0] la;
      logic [31:0] sa;
      ld = ($urandom_range(0, 9) < 6);
      st = ($urandom_range(0, 9) < 6);
      la = {$urandom_range(0, 32'hFF_FFFF), ADDR_W'(0)} | 32'(known[$urandom_range(0, 10)]);
      sa = {$urandom_range(0, 32'hFF_FFFF), ADDR_W'(0)} | 32'(known[$urandom_range(0, 10)]);
      step(1'b0, ld, la, st, sa, $urandom);
    end
    idle(SB_DEPTH + 2);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
